config_bank_loader: RTL and testbench
=====================================

Name: config_bank_loader

Overview:
- Memory-bank configuration loader sitting directly upstream of a tile's flattened bl/wl configuration inputs; its bl/wl outputs connect 1:1 to a tile's bl/wl buses.
- Accepts the bitstream as DATA_W-bit words over a valid/ready stream.
- Programs the tile one cell at a time: drives bl[addr] with the data bit, pulses wl[addr] with setup/hold margins, and reports completion.

Parameters:
- NUM_CELLS, 1260: configuration cells in the target tile; width of bl and wl.
- DATA_W, 8: bitstream word width; bits consumed LSB first.
- WL_PULSE, 2: wl high time per cell, in clk cycles; legal range 1..15.
- ADDR_W, 11: cell address counter width; must satisfy 2^ADDR_W >= NUM_CELLS.

Ports:
- clk  in  1  configuration clock.
- reset  in  1  asynchronous, active-low reset.
- cfg_start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- cfg_abort  in  1  synchronous abort; honoured in any non-IDLE state.
- cfg_valid  in  1  bitstream word valid.
- cfg_data  in  DATA_W  bitstream word; bit 0 is written first.
- cfg_ready  out  1  loader can accept a word.
- cfg_busy  out  1  high in every state except IDLE.
- cfg_done  out  1  one-cycle pulse after the last cell is written.
- cfg_addr  out  ADDR_W  index of the cell currently being written (debug).
- bl  out  [0:NUM_CELLS-1]  bit lines; only bl[cfg_addr] may be non-zero.
- wl  out  [0:NUM_CELLS-1]  word lines; at most one bit high, never while bl is changing.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; bl=0, wl=0, cfg_ready=0, cfg_busy=0, cfg_done=0, cfg_addr=0; internal word/bit/pulse counters cleared. A reset mid-load drops wl immediately, and the partial load is not resumed.
- States: IDLE, FETCH, SETUP, PULSE, HOLD, DONE. All outputs are registered.
- IDLE: cfg_ready=0. cfg_start=1 -> FETCH; cfg_addr=0, bit index=0.
- FETCH: cfg_ready=1. On cfg_valid&&cfg_ready the word is latched -> SETUP. cfg_ready deasserts the following cycle, so only one word is in flight.
- SETUP (1 cycle): bl[addr]=word[bit]; all other bl bits 0; wl=0 -> PULSE.
- PULSE (WL_PULSE cycles): wl[addr]=1 and bl held -> HOLD.
- HOLD (1 cycle): wl=0 and bl held. Then:
  - if addr==NUM_CELLS-1 -> DONE;
  - else if bit==DATA_W-1 -> FETCH, with addr+1 and bit=0;
  - else -> SETUP, with addr+1 and bit+1.
- Per-cell cost is WL_PULSE+2 cycles; per-word cost is DATA_W*(WL_PULSE+2) cycles plus the FETCH wait (1 cycle minimum).
- Last word: when NUM_CELLS is not a multiple of DATA_W, the unused upper bits of the final word are ignored and no extra word is requested.
- DONE (1 cycle): cfg_done=1, bl=0, wl=0 -> IDLE. cfg_busy is high in DONE.
- cfg_start while not in IDLE: ignored.
- cfg_abort:
  - in any non-IDLE state -> IDLE next cycle; bl=0, wl=0, cfg_done not asserted.
  - if abort and a FETCH handshake occur in the same cycle, abort wins and the word is discarded.
  - in PULSE, wl falls at the next edge.
- cfg_start and cfg_abort together in IDLE: abort has no effect and start is honoured.
- cfg_valid while cfg_ready=0: held off; data is not consumed.
- Invariant: no cycle has bl and wl changing on the same edge.

Test Plan:
- NUM_CELLS=12, DATA_W=8, WL_PULSE=2; start, then words 0xA5 and 0x0F with cfg_valid held high:
  - cells 0..11 written with bits 1,0,1,0,0,1,0,1,1,1,1,1;
  - each wl[i] high exactly 2 cycles;
  - cfg_done pulses once 50 cycles after the first handshake;
  - word-2 bits 4..7 are ignored;
  - exactly 2 handshakes occur.
- Backpressure: cfg_valid low for 5 cycles in FETCH before word 2 -> cfg_ready stays high; no bl/wl activity; cfg_done is delayed by exactly 5 cycles.
- Abort during PULSE of cell 3 -> wl[3] low next cycle; bl=0; IDLE; no cfg_done; a fresh start reloads from cell 0.
- Async reset asserted mid-PULSE, between clock edges -> wl and bl go to 0 without a clock edge; cfg_busy=0.
- cfg_start pulsed during a load -> no effect; a single cfg_done.
- Protocol checker over all tests:
  - popcount(wl)<=1;
  - bl stable during the cycle before, during, and after any wl pulse;
  - bl non-zero only at cfg_addr.

Source files
------------

// File: rtl/config_bank_loader_if.sv
// Bitstream stream and control/status bundle between a configuration source
// (master) and the bank loader (slave).
interface config_bank_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
) ();
  logic              cfg_start;
  logic              cfg_abort;
  logic              cfg_valid;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_ready;
  logic              cfg_busy;
  logic              cfg_done;
  logic [ADDR_W-1:0] cfg_addr;

  modport master (
    output cfg_start, cfg_abort, cfg_valid, cfg_data,
    input  cfg_ready, cfg_busy, cfg_done, cfg_addr
  );

  modport slave (
    input  cfg_start, cfg_abort, cfg_valid, cfg_data,
    output cfg_ready, cfg_busy, cfg_done, cfg_addr
  );
endinterface

// File: rtl/config_bank_loader.sv
// Memory-bank configuration loader. Takes the bitstream one word at a time and
// writes it into the tile one cell at a time: bl[addr] is set up, wl[addr] is
// pulsed for WL_PULSE cycles, then held off for one cycle before bl moves on.
// Every output is a register written when its state is entered, so bl and wl
// never change on the same edge during a normal load.
module config_bank_loader #(
  parameter int NUM_CELLS = 1260,
  parameter int DATA_W    = 8,
  parameter int WL_PULSE  = 2,
  parameter int ADDR_W    = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  config_bank_loader_if.slave  bus,
  output logic [0:NUM_CELLS-1] bl,
  output logic [0:NUM_CELLS-1] wl
);
  localparam int              BIT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_CELLS - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(DATA_W - 1);
  localparam logic [3:0]        LAST_PULSE = 4'(WL_PULSE - 1);

  typedef enum logic [2:0] {IDLE, FETCH, SETUP, PULSE, HOLD, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] word;
  logic [BIT_W-1:0]  bit_idx;
  logic [3:0]        pulse_cnt;
  logic [ADDR_W-1:0] next_addr;
  logic [BIT_W-1:0]  next_bit;

  assign next_addr = bus.cfg_addr + 1'b1;
  assign next_bit  = bit_idx + 1'b1;

  // Load sequencer; outputs are set on the edge that enters the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      word          <= '0;
      bit_idx       <= '0;
      pulse_cnt     <= '0;
      bl            <= '0;
      wl            <= '0;
      bus.cfg_ready <= 1'b0;
      bus.cfg_busy  <= 1'b0;
      bus.cfg_done  <= 1'b0;
      bus.cfg_addr  <= '0;
    end else begin
      bus.cfg_done <= 1'b0;
      if (state != IDLE && bus.cfg_abort) begin
        // Abort beats a same-cycle handshake; the word is simply dropped.
        state         <= IDLE;
        bl            <= '0;
        wl            <= '0;
        bus.cfg_ready <= 1'b0;
        bus.cfg_busy  <= 1'b0;
        bus.cfg_addr  <= '0;
        bit_idx       <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.cfg_start) begin
              state         <= FETCH;
              bus.cfg_ready <= 1'b1;
              bus.cfg_busy  <= 1'b1;
              bus.cfg_addr  <= '0;
              bit_idx       <= '0;
            end
          end
          FETCH: begin
            // A fresh word always starts at bit 0, so drive bl straight from the bus.
            if (bus.cfg_valid) begin
              word               <= bus.cfg_data;
              bus.cfg_ready      <= 1'b0;
              bl                 <= '0;
              bl[bus.cfg_addr]   <= bus.cfg_data[0];
              state              <= SETUP;
            end
          end
          SETUP: begin
            wl[bus.cfg_addr] <= 1'b1;
            pulse_cnt        <= '0;
            state            <= PULSE;
          end
          PULSE: begin
            if (pulse_cnt == LAST_PULSE) begin
              wl    <= '0;
              state <= HOLD;
            end else begin
              pulse_cnt <= pulse_cnt + 1'b1;
            end
          end
          HOLD: begin
            if (bus.cfg_addr == LAST_ADDR) begin
              // Any unused upper bits of a partial final word are never looked at.
              bl           <= '0;
              bus.cfg_done <= 1'b1;
              state        <= DONE;
            end else if (bit_idx == LAST_BIT) begin
              bl            <= '0;
              bus.cfg_addr  <= next_addr;
              bit_idx       <= '0;
              bus.cfg_ready <= 1'b1;
              state         <= FETCH;
            end else begin
              bl            <= '0;
              bl[next_addr] <= word[next_bit];
              bus.cfg_addr  <= next_addr;
              bit_idx       <= next_bit;
              state         <= SETUP;
            end
          end
          DONE: begin
            bus.cfg_busy <= 1'b0;
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_config_bank_loader.sv
// Directed bench for config_bank_loader on a 12-cell tile, 8-bit words, 2-cycle wl pulse.
module tb_config_bank_loader;
  localparam int NC = 12;
  localparam int DW = 8;
  localparam int WP = 2;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [0:NC-1] bl, wl;

  always #5 clk = ~clk;

  config_bank_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  config_bank_loader #(.NUM_CELLS(NC), .DATA_W(DW), .WL_PULSE(WP), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .bl    (bl),
    .wl    (wl)
  );

  int vectors = 0;
  int errors  = 0;

  // Monitor state (written only by the monitor process).
  int cyc = 0, hs_cnt = 0, done_cnt = 0, done_cyc = 0, prot_err = 0;
  int hs_log [256];
  int wl_cnt [NC];
  logic wr_bit [NC];
  logic [0:NC-1] prev_bl = '0, prev_wl = '0;

  // Written only by the stimulus process.
  bit mon_en = 1'b0;
  bit skip   = 1'b0;

  function automatic logic [0:NC-1] cell_mask(input logic [AW-1:0] a);
    cell_mask = '0;
    if (int'(a) < NC) cell_mask[a] = 1'b1;
  endfunction

  // Cycle monitor: handshakes, done pulses, per-cell writes and protocol rules.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mon_en) begin
      if (bus.cfg_valid && bus.cfg_ready) begin
        hs_log[hs_cnt & 255] <= cyc;
        hs_cnt <= hs_cnt + 1;
      end
      if (bus.cfg_done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      for (int i = 0; i < NC; i++)
        if (wl[i]) begin
          wl_cnt[i] <= wl_cnt[i] + 1;
          if (!prev_wl[i]) wr_bit[i] <= bl[i];
        end
      if ($countones(wl) > 1) begin
        prot_err <= prot_err + 1;
        $display("FAIL wl_onehot: wl=%b, required at most one bit high", wl);
      end
      if ((bl & ~cell_mask(bus.cfg_addr)) != '0) begin
        prot_err <= prot_err + 1;
        $display("FAIL bl_at_addr: bl=%b addr=%0d, required bl only at addr", bl, bus.cfg_addr);
      end
      if (!skip && wl !== prev_wl && bl !== prev_bl) begin
        prot_err <= prot_err + 1;
        $display("FAIL bl_wl_same_edge: bl %b->%b wl %b->%b, required not both", prev_bl, bl, prev_wl, wl);
      end
      if (!skip && wl != '0 && prev_wl != '0 && bl !== prev_bl) begin
        prot_err <= prot_err + 1;
        $display("FAIL bl_stable_pulse: bl %b->%b while wl high, required stable", prev_bl, bl);
      end
      if (bus.cfg_ready && (bl != '0 || wl != '0)) begin
        prot_err <= prot_err + 1;
        $display("FAIL fetch_quiet: bl=%b wl=%b in FETCH, required zero", bl, wl);
      end
    end
    prev_bl <= bl;
    prev_wl <= wl;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a load and feed two words; gap = FETCH cycles of valid-low before word 2,
  // start_at = loop iteration at which a stray cfg_start is pulsed (-1 for none).
  task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input int gap,
                          input int start_at, output int hs_first, output int n_hs,
                          output int n_done, output int done_at);
    int b_hs = hs_cnt;
    int b_done = done_cnt;
    int idx = 0;
    int gl = gap;
    bit ok = 1'b0;
    bit hs;
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (idx == 0) begin
        bus.cfg_valid = 1'b1; bus.cfg_data = w0;
      end else if (idx == 1) begin
        if (bus.cfg_ready && gl > 0) begin
          bus.cfg_valid = 1'b0; gl--;
        end else begin
          bus.cfg_valid = 1'b1; bus.cfg_data = w1;
        end
      end else begin
        bus.cfg_valid = 1'b1; bus.cfg_data = 8'hFF;
      end
      bus.cfg_start = (k == start_at);
      hs = bus.cfg_valid && bus.cfg_ready;
      tick();
      if (hs) idx++;
      if (done_cnt != b_done) begin ok = 1'b1; break; end
    end
    bus.cfg_start = 1'b0;
    repeat (3) tick();
    bus.cfg_valid = 1'b0;
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL load_timeout: no cfg_done within 300 cycles, required one");
    end
    hs_first = (hs_cnt > b_hs) ? hs_log[b_hs & 255] : 0;
    n_hs     = hs_cnt - b_hs;
    n_done   = done_cnt - b_done;
    done_at  = done_cyc;
  endtask

  task automatic test_reset();
    bus.cfg_start = 1'b0; bus.cfg_abort = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_data = '0;
    #12;
    vectors++; if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", bus.cfg_ready); end
    vectors++; if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.cfg_busy); end
    vectors++; if (bus.cfg_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus.cfg_done); end
    vectors++; if (bus.cfg_addr !== 4'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", bus.cfg_addr); end
    vectors++; if (bl !== 12'd0) begin errors++; $display("FAIL rst_bl: got %b want 0", bl); end
    vectors++; if (wl !== 12'd0) begin errors++; $display("FAIL rst_wl: got %b want 0", wl); end
    tick();
    reset = 1'b1;
    mon_en = 1'b1;
    repeat (2) tick();
    vectors++; if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", bus.cfg_busy); end
  endtask

  task automatic test_start_abort();
    bus.cfg_start = 1'b1; bus.cfg_abort = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    vectors++; if (bus.cfg_busy !== 1'b1) begin errors++; $display("FAIL idle_abort_busy: got %b want 1", bus.cfg_busy); end
    vectors++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL idle_abort_ready: got %b want 1", bus.cfg_ready); end
    // Abort together with a handshake in FETCH: the word must not be used.
    bus.cfg_valid = 1'b1; bus.cfg_data = 8'hFF;
    tick();
    bus.cfg_abort = 1'b0; bus.cfg_valid = 1'b0;
    vectors++; if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL fetch_abort_busy: got %b want 0", bus.cfg_busy); end
    vectors++; if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL fetch_abort_ready: got %b want 0", bus.cfg_ready); end
    tick();
    vectors++; if (bl !== 12'd0) begin errors++; $display("FAIL fetch_abort_bl: got %b want 0", bl); end
  endtask

  task automatic test_basic();
    int hf, nh, nd, da;
    int base [NC];
    int pe = prot_err;
    logic [15:0] exp = {8'h0F, 8'hA5};
    base = wl_cnt;
    run_load(8'hA5, 8'h0F, 0, -1, hf, nh, nd, da);
    for (int i = 0; i < NC; i++) begin
      vectors++; if (wr_bit[i] !== exp[i]) begin errors++; $display("FAIL basic_bit%0d: got %b want %b", i, wr_bit[i], exp[i]); end
      vectors++; if (wl_cnt[i] - base[i] != WP) begin errors++; $display("FAIL basic_wl%0d: got %0d cycles want %0d", i, wl_cnt[i] - base[i], WP); end
    end
    vectors++; if (da - hf != 50) begin errors++; $display("FAIL basic_latency: got %0d want 50", da - hf); end
    vectors++; if (nh != 2) begin errors++; $display("FAIL basic_handshakes: got %0d want 2", nh); end
    vectors++; if (nd != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", nd); end
    vectors++; if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", bus.cfg_busy); end
    vectors++; if (prot_err != pe) begin errors++; $display("FAIL basic_protocol: got %0d violations want 0", prot_err - pe); end
  endtask

  task automatic test_backpressure();
    int hf, nh, nd, da;
    int pe = prot_err;
    logic [15:0] exp = {8'h0F, 8'hA5};
    run_load(8'hA5, 8'h0F, 5, -1, hf, nh, nd, da);
    for (int i = 0; i < NC; i++) begin
      vectors++; if (wr_bit[i] !== exp[i]) begin errors++; $display("FAIL bp_bit%0d: got %b want %b", i, wr_bit[i], exp[i]); end
    end
    vectors++; if (da - hf != 55) begin errors++; $display("FAIL bp_latency: got %0d want 55", da - hf); end
    vectors++; if (nh != 2) begin errors++; $display("FAIL bp_handshakes: got %0d want 2", nh); end
    vectors++; if (nd != 1) begin errors++; $display("FAIL bp_done_count: got %0d want 1", nd); end
    vectors++; if (prot_err != pe) begin errors++; $display("FAIL bp_protocol: got %0d violations want 0", prot_err - pe); end
  endtask

  task automatic test_abort();
    int hf, nh, nd, da;
    int base [NC];
    int b_done = done_cnt;
    int pe;
    bit seen = 1'b0;
    logic [15:0] exp = {8'h09, 8'h3C};
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b1; bus.cfg_data = 8'hA5;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (wl[3]) begin seen = 1'b1; break; end
    end
    vectors++;
    if (!seen) begin errors++; $display("FAIL abort_wait: wl[3] never high, required high"); end
    skip = 1'b1;
    bus.cfg_abort = 1'b1;
    tick();
    bus.cfg_abort = 1'b0; bus.cfg_valid = 1'b0;
    vectors++; if (wl !== 12'd0) begin errors++; $display("FAIL abort_wl: got %b want 0", wl); end
    vectors++; if (bl !== 12'd0) begin errors++; $display("FAIL abort_bl: got %b want 0", bl); end
    vectors++; if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.cfg_busy); end
    repeat (3) tick();
    skip = 1'b0;
    vectors++; if (done_cnt != b_done) begin errors++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt - b_done); end
    pe = prot_err;
    base = wl_cnt;
    run_load(8'h3C, 8'h09, 0, -1, hf, nh, nd, da);
    for (int i = 0; i < NC; i++) begin
      vectors++; if (wr_bit[i] !== exp[i]) begin errors++; $display("FAIL reload_bit%0d: got %b want %b", i, wr_bit[i], exp[i]); end
      vectors++; if (wl_cnt[i] - base[i] != WP) begin errors++; $display("FAIL reload_wl%0d: got %0d want %0d", i, wl_cnt[i] - base[i], WP); end
    end
    vectors++; if (nd != 1) begin errors++; $display("FAIL reload_done_count: got %0d want 1", nd); end
    vectors++; if (prot_err != pe) begin errors++; $display("FAIL reload_protocol: got %0d violations want 0", prot_err - pe); end
  endtask

  task automatic test_async_reset();
    bit seen = 1'b0;
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b1; bus.cfg_data = 8'hFF;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (wl[2]) begin seen = 1'b1; break; end
    end
    vectors++;
    if (!seen) begin errors++; $display("FAIL areset_wait: wl[2] never high, required high"); end
    #2;
    skip = 1'b1;
    reset = 1'b0;
    #1;
    vectors++; if (wl !== 12'd0) begin errors++; $display("FAIL areset_wl: got %b want 0", wl); end
    vectors++; if (bl !== 12'd0) begin errors++; $display("FAIL areset_bl: got %b want 0", bl); end
    vectors++; if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", bus.cfg_busy); end
    vectors++; if (bus.cfg_addr !== 4'd0) begin errors++; $display("FAIL areset_addr: got %0d want 0", bus.cfg_addr); end
    tick();
    reset = 1'b1;
    bus.cfg_valid = 1'b0;
    repeat (3) tick();
    skip = 1'b0;
    vectors++; if (bus.cfg_busy !== 1'b0) begin errors++; $display("FAIL areset_resume: busy got %b want 0", bus.cfg_busy); end
    vectors++; if (wl !== 12'd0) begin errors++; $display("FAIL areset_resume_wl: got %b want 0", wl); end
  endtask

  task automatic test_start_ignored();
    int hf, nh, nd, da;
    int pe = prot_err;
    logic [15:0] exp = {8'h06, 8'h5A};
    run_load(8'h5A, 8'h06, 0, 12, hf, nh, nd, da);
    for (int i = 0; i < NC; i++) begin
      vectors++; if (wr_bit[i] !== exp[i]) begin errors++; $display("FAIL restart_bit%0d: got %b want %b", i, wr_bit[i], exp[i]); end
    end
    vectors++; if (nd != 1) begin errors++; $display("FAIL restart_done_count: got %0d want 1", nd); end
    vectors++; if (da - hf != 50) begin errors++; $display("FAIL restart_latency: got %0d want 50", da - hf); end
    vectors++; if (nh != 2) begin errors++; $display("FAIL restart_handshakes: got %0d want 2", nh); end
    vectors++; if (prot_err != pe) begin errors++; $display("FAIL restart_protocol: got %0d violations want 0", prot_err - pe); end
  endtask

  initial begin
    test_reset();
    test_start_abort();
    test_basic();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
